// File: rtl/tt_um_uart_tx_if.sv
// Pin bundle of the UART transmitter tile.
//   ena     : power-good indication, always 1, not used by the logic
//   ui_in   : byte to transmit
//   uio_in  : bit 0 is the send request level, bits 7:1 unused
//   uo_out  : {4'b0, overrun, done, busy, tx}
//   uio_out : constant 0
//   uio_oe  : constant 0 (bidirectional pins are inputs)
// master = the side that drives the request and data, slave = the transmitter.
interface tt_um_uart_tx_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// A rising edge on the send request (uio_in[0], asynchronous) latches ui_in
// and emits one frame on uo_out[0].
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pin bundle (slave side), see tt_um_uart_tx_if
//           uo_out = {4'b0, overrun, done, busy, tx}; uio_out/uio_oe = 0
module tt_um_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  tt_um_uart_tx_if.slave bus
);

  // Timer must hold the longest interval, the two-bit stop period.
  localparam int TW = $clog2(CLKS_PER_BIT * 2);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(CLKS_PER_BIT * STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic          req_p0;
  logic          req_p1;
  logic          req_d_p2;
  logic          edge_p2;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
  logic          ovr_q;

  // Stage p0/p1: two-flop synchronizer; stage p2: registered rising-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_p0   <= 1'b0;
      req_p1   <= 1'b0;
      req_d_p2 <= 1'b0;
      edge_p2  <= 1'b0;
    end else begin
      req_p0   <= bus.uio_in[0];
      req_p1   <= req_p0;
      req_d_p2 <= req_p1;
      edge_p2  <= req_p1 & ~req_d_p2;
    end
  end

  // Frame FSM: tx is driven straight from a flop so the line never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A request arriving mid-frame is dropped and remembered until reset.
      if (edge_p2 && (state != IDLE)) ovr_q <= 1'b1;

      case (state)
        IDLE: begin
          if (edge_p2) begin
            shreg  <= bus.ui_in;
            state  <= START;
            timer  <= '0;
            tx_q   <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (timer == BIT_LAST) begin
            timer   <= '0;
            bit_idx <= 3'd0;
            state   <= DATA;
            tx_q    <= shreg[0];
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx_q  <= ^shreg;
              end else begin
                state <= STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shreg[bit_idx + 3'd1];
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        PARITY: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            state <= STOP;
            tx_q  <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (timer == STOP_LAST) begin
            timer  <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.uo_out  = {4'b0000, ovr_q, done_q, busy_q, tx_q};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.ena, bus.uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_uart_tx.sv
// Bench for tt_um_uart_tx: instance 0 is 8N1, instance 1 is 8E2, both 4 clocks
// per bit. Requests push the expected byte into a per-instance queue; a monitor
// per instance waits for a start bit, pops the byte and compares the whole frame
// against a bit-slot model built from the frame format.
module tb_tt_um_uart_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       req_r [2];
  logic [7:0] ui_r  [2];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic [7:0] uo [2];

  tt_um_uart_tx_if if0 ();
  tt_um_uart_tx_if if1 ();

  assign if0.ena    = 1'b1;
  assign if0.ui_in  = ui_r[0];
  assign if0.uio_in = {7'b0, req_r[0]};
  assign if1.ena    = 1'b1;
  assign if1.ui_in  = ui_r[1];
  assign if1.uio_in = {7'b0, req_r[1]};
  assign uo[0] = if0.uo_out;
  assign uo[1] = if1.uo_out;

  tt_um_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  tt_um_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int frame_len(input int k);
    return (k == 0) ? CPB * 10 : CPB * 12;
  endfunction

  // Bit slot j of a frame: start, 8 data LSB first, optional parity, stop(s).
  function automatic logic exp_bit(input int k, input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return d[j-1];
    if (k == 1 && j == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic monitor(input int k);
    int len, sz, bad_tx, bad_busy;
    logic [7:0] d, got;
    bit aborted;
    len = frame_len(k);
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) continue;
      chk($sformatf("idle_done%0d", k), uo[k][2], 1'b0);
      if (uo[k][0] == 1'b0) begin
        sz = (k == 0) ? exp_q0.size() : exp_q1.size();
        chk($sformatf("frame_expected%0d", k), (sz != 0), 1);
        d = 8'h00;
        if (sz != 0) begin
          if (k == 0) d = exp_q0.pop_front();
          else        d = exp_q1.pop_front();
        end
        bad_tx = 0; bad_busy = 0; got = 8'h00; aborted = 0;
        for (int i = 0; i < len; i++) begin
          if (i > 0) begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin aborted = 1; break; end
          end
          if (uo[k][0] !== exp_bit(k, d, i / CPB)) bad_tx++;
          if (uo[k][1] !== 1'b1) bad_busy++;
          if ((i % CPB) == CPB / 2 && i / CPB >= 1 && i / CPB <= 8) got[i/CPB-1] = uo[k][0];
        end
        if (!aborted) begin
          chk($sformatf("frame_tx_cycles%0d", k), bad_tx, 0);
          chk($sformatf("frame_busy_cycles%0d", k), bad_busy, 0);
          chk($sformatf("rx_byte%0d", k), got, d);
          @(negedge clk);
          if (rst_n === 1'b1) begin
            chk($sformatf("done_pulse%0d", k), uo[k][2], 1'b1);
            chk($sformatf("busy_end%0d", k), uo[k][1], 1'b0);
            chk($sformatf("tx_end%0d", k), uo[k][0], 1'b1);
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic pulse(input int k, input logic [7:0] b, input int w);
    @(posedge clk);
    #1;
    ui_r[k]  = b;
    req_r[k] = 1'b1;
    if (k == 0) exp_q0.push_back(b);
    else        exp_q1.push_back(b);
    repeat (w) @(posedge clk);
    #1;
    req_r[k] = 1'b0;
  endtask

  task automatic wait_busy(input int k);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uo[k][1] == 1'b1) return;
    end
    chk($sformatf("busy_timeout%0d", k), uo[k][1], 1'b1);
  endtask

  task automatic wait_idle(input int k, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (uo[k][1] == 1'b0) return;
    end
    chk($sformatf("idle_timeout%0d", k), uo[k][1], 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] b;
    int k, w;
    rst_n    = 1'b0;
    req_r[0] = 1'b0; req_r[1] = 1'b0;
    ui_r[0]  = 8'h00; ui_r[1] = 8'h00;
    #12;
    chk("rst_uo0", uo[0], 8'h01);
    chk("rst_uo1", uo[1], 8'h01);
    chk("rst_uio_out", if0.uio_out, 8'h00);
    chk("rst_uio_oe", if0.uio_oe, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 0x55 with request latency: tx falls on the third edge after the first sample.
    @(posedge clk); #1;
    ui_r[0] = 8'h55; req_r[0] = 1'b1; exp_q0.push_back(8'h55);
    @(posedge clk); #1 req_r[0] = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); chk("latency_pre_tx", uo[0][0], 1'b1);
    @(posedge clk);
    @(negedge clk); chk("latency_tx", uo[0][0], 1'b0);
    wait_idle(0, 100);
    chk("ovr_after_55", uo[0][3], 1'b0);

    // 8E2: 0x07 has odd weight so the parity bit is 1, frame 48 cycles.
    pulse(1, 8'h07, 1);
    wait_busy(1);
    ui_r[1] = 8'hF0;
    wait_idle(1, 100);

    // Held request yields exactly one frame and no overrun.
    @(posedge clk); #1;
    ui_r[0] = 8'hA3; req_r[0] = 1'b1; exp_q0.push_back(8'hA3);
    repeat (200) @(posedge clk);
    #1 req_r[0] = 1'b0;
    repeat (5) @(posedge clk);
    chk("hold_ovr", uo[0][3], 1'b0);

    // Second request 10 cycles into a frame is dropped and flags overrun.
    pulse(0, 8'h3C, 1);
    wait_busy(0);
    repeat (9) @(posedge clk);
    #1; ui_r[0] = 8'hFF; req_r[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 req_r[0] = 1'b0;
    wait_idle(0, 100);
    chk("overrun_set", uo[0][3], 1'b1);
    pulse(0, 8'h12, 2);
    wait_busy(0);
    wait_idle(0, 100);
    chk("overrun_sticky", uo[0][3], 1'b1);

    // Reset mid-frame aborts at once; a level held through reset is a new request.
    pulse(0, 8'hC6, 1);
    wait_busy(0);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    ui_r[1] = 8'h5A; req_r[1] = 1'b1;
    #1;
    chk("async_rst_tx", uo[0][0], 1'b1);
    chk("async_rst_busy", uo[0][1], 1'b0);
    chk("async_rst_done", uo[0][2], 1'b0);
    chk("async_rst_ovr", uo[0][3], 1'b0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1; exp_q1.push_back(8'h5A);
    pulse(0, 8'h96, 1);
    wait_busy(0);
    wait_idle(0, 100);
    wait_idle(1, 100);
    req_r[1] = 1'b0;
    repeat (3) @(posedge clk);

    // Request whose edge lands in the done cycle starts the next frame immediately.
    pulse(0, 8'h81, 1);
    wait_busy(0);
    repeat (frame_len(0) - 3) @(posedge clk);
    #1; ui_r[0] = 8'h4E; req_r[0] = 1'b1; exp_q0.push_back(8'h4E);
    repeat (3) @(posedge clk);
    @(negedge clk); chk("b2b_done", uo[0][2], 1'b1);
    @(negedge clk); chk("b2b_start", uo[0][0], 1'b0);
    #1 req_r[0] = 1'b0;
    wait_idle(0, 100);
    chk("b2b_ovr", uo[0][3], 1'b0);

    // Random bytes, widths and idle gaps on both instances.
    for (int n = 0; n < 24; n++) begin
      k = $urandom_range(0, 1);
      b = 8'($urandom);
      w = $urandom_range(1, 4);
      pulse(k, b, w);
      wait_busy(k);
      ui_r[k] = 8'($urandom);
      wait_idle(k, 200);
      repeat ($urandom_range(1, 4)) @(posedge clk);
    end

    repeat (10) @(posedge clk);
    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tt_um_uart_tx.md
TT_UM_UART_TX -- requirements
Module: tt_um_uart_tx

Interface
REQ-001: Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (legal range 2..65535).
REQ-002: Parameter PARITY_EN, default 0; when 1, an even-parity bit is inserted after the data bits.
REQ-003: Parameter STOP_BITS, default 1; legal values 1 or 2.
REQ-004: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005: rst_n  input  1  asynchronous, active-low reset.
REQ-006: ena  input  1  always 1 when powered; unused.
REQ-007: ui_in  input  8  byte to transmit; sampled only at request acceptance.
REQ-008: uio_in  input  8  bit 0 is the send request (asynchronous level); bits 7:1 unused.
REQ-009: uo_out  output  8  bit 0 tx serial line; bit 1 busy; bit 2 done pulse; bit 3 overrun (sticky); bits 7:4 are 0.
REQ-010: uio_out  output  8  constant 0.
REQ-011: uio_oe  output  8  constant 0 (all bidirectional pins are inputs).

Function
REQ-012: uio_in[0] SHALL pass through a 2-flop synchronizer, followed by a registered rising-edge detector; a held-high level SHALL produce exactly one request.
REQ-013: FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-014: IDLE: tx=1, busy=0; on a detected edge, ui_in SHALL be latched into the shift register and the FSM SHALL move to START.
REQ-015: If N is the first clk edge that samples uio_in[0]=1, tx SHALL go low on the register update at edge N+3.
REQ-016: START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-017: DATA: 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles; a 3-bit index counts 0..7 with no wrap past 7; then PARITY if PARITY_EN=1, otherwise STOP.
REQ-018: PARITY: tx = XOR of the 8 latched bits, held CLKS_PER_BIT cycles, then STOP.
REQ-019: STOP: tx=1 for CLKS_PER_BIT*STOP_BITS cycles, then IDLE.
REQ-020: The bit timer SHALL be wide enough to hold CLKS_PER_BIT*2-1 without overflow; it SHALL reset to 0 on every state or bit change.
REQ-021: Total frame length: CLKS_PER_BIT*(1+8+PARITY_EN+STOP_BITS) cycles of tx from first 0 to return to IDLE.
REQ-022: busy=1 in every state except IDLE.
REQ-023: done SHALL be 1 for exactly one cycle: the first cycle in IDLE after STOP.
REQ-024: A detected edge while the FSM is not IDLE SHALL be dropped and SHALL set overrun=1; the in-flight frame SHALL be unaffected.
REQ-025: A detected edge in the same cycle that done=1 (FSM in IDLE) SHALL be accepted normally, without setting overrun.
REQ-026: overrun SHALL be cleared only by reset.
REQ-027: Changes on ui_in after acceptance SHALL NOT alter the frame in flight.
REQ-028: All outputs SHALL be registered or constant; tx SHALL be glitch-free.

Reset
REQ-029: While rst_n=0, the following SHALL hold immediately and asynchronously: FSM=IDLE, tx=1, busy=0, done=0, overrun=0, timer/index/shift register=0, synchronizer and edge flops=0.
REQ-030: Reset asserted mid-frame SHALL abort the frame, with tx=1 at once; no done pulse SHALL follow.
REQ-031: After rst_n rises, a uio_in[0] already held high SHALL count as one new request, because the synchronizer resets to 0.

Verification
REQ-032: CLKS_PER_BIT=4, ui_in=0x55, pulse uio_in[0] -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; busy high 40 cycles; one done pulse.
REQ-033: PARITY_EN=1, STOP_BITS=2, CLKS_PER_BIT=4, ui_in=0x07 -> parity bit 1, stop held 8 cycles, frame 48 cycles.
REQ-034: Hold uio_in[0]=1 for 200 cycles with CLKS_PER_BIT=4 -> exactly one frame sent; overrun stays 0.
REQ-035: Second request 10 cycles into a frame -> frame for the first byte unchanged; overrun=1 and stays 1; no second frame.
REQ-036: rst_n low at cycle 20 of a frame -> tx=1, busy=0 asynchronously; a fresh request after release sends a correct full frame.
REQ-037: New request timed so its edge is detected in the done cycle -> second frame's start bit begins on the next cycle; overrun=0.
